// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty, sticky error flags and optional FWFT read.
// Write rejected while full, read rejected while empty; rdata is one cycle after rinc (FWFT=0) or head-of-queue (FWFT=1).
module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter bit FWFT     = 1'b0,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] INC      = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AF_TH    = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_TH    = AE_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] FULL_XOR = {1'b1, {ASIZE{1'b0}}};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_nxt, rptr_nxt, count_nxt;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] head_nxt;

  always_comb begin
    wr_ok     = winc && !wfull;
    rd_ok     = rinc && !rempty;
    wptr_nxt  = wr_ok ? wptr + INC : wptr;
    rptr_nxt  = rd_ok ? rptr + INC : rptr;
    count_nxt = count;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + INC;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - INC;
    end
    // The entry being written this cycle becomes the head when the queue was empty
    // (or drains to it), so forward it instead of reading stale memory.
    head_nxt = mem[rptr_nxt[ASIZE-1:0]];
    if (wr_ok && (wptr[ASIZE-1:0] == rptr_nxt[ASIZE-1:0])) begin
      head_nxt = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rdata        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      wfull        <= ((wptr_nxt ^ rptr_nxt) == FULL_XOR);
      rempty       <= (wptr_nxt == rptr_nxt);
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
      if (FWFT) begin
        if (wptr_nxt != rptr_nxt) begin
          rdata <= head_nxt;
        end
      end else if (rd_ok) begin
        rdata <= mem[rptr[ASIZE-1:0]];
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-read FIFO (u_dut) and FWFT FIFO (u_fwft), DEPTH=16, sharing clk/rst.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0, f_wdata = '0;
  logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic       f_winc = 1'b0, f_rinc = 1'b0, f_clr_err = 1'b0;
  logic [7:0] rdata, f_rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic       f_wfull, f_rempty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] count, f_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc), .clr_err(f_clr_err),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (rempty !== 1'b1 || wfull !== 1'b0) begin n_fail++; $display("FAIL reset_flags: rempty=%b wfull=%b want 1 0", rempty, wfull); end
    n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost: ae=%b af=%b want 1 0", almost_empty, almost_full); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: ov=%b un=%b want 0 0", overflow, underflow); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    n_cmp++; if (f_rempty !== 1'b1 || f_count !== 5'd0 || f_rdata !== 8'h00 || f_wfull !== 1'b0 ||
                 f_almost_empty !== 1'b1 || f_almost_full !== 1'b0 || f_overflow !== 1'b0 || f_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_fwft: rempty=%b count=%0d rdata=%h want 1 0 00", f_rempty, f_count, f_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i);
      winc  = 1'b1;
      tick();
      n_cmp++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 14)); end
      n_cmp++; if (almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i + 1 <= 2)); end
      n_cmp++; if (wfull !== (i == 15) || rempty !== 1'b0) begin n_fail++; $display("FAIL fill_flags[%0d]: wfull=%b rempty=%b", i, wfull, rempty); end
    end
    wdata = 8'hFF;
    tick();
    winc = 1'b0;
    n_cmp++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fill_overflow: ov=%b count=%0d want 1 16", overflow, count); end
  endtask

  task automatic test_drain;
    for (int j = 0; j < 16; j++) begin
      rinc = 1'b1;
      tick();
      n_cmp++; if (rdata !== 8'(j)) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %h want %h", j, rdata, 8'(j)); end
      n_cmp++; if (count !== 5'(15 - j)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", j, count, 15 - j); end
      n_cmp++; if (almost_empty !== (15 - j <= 2)) begin n_fail++; $display("FAIL drain_ae[%0d]: got %b want %b", j, almost_empty, (15 - j <= 2)); end
      n_cmp++; if (rempty !== (j == 15)) begin n_fail++; $display("FAIL drain_rempty[%0d]: got %b want %b", j, rempty, (j == 15)); end
    end
    tick();
    rinc = 1'b0;
    n_cmp++; if (underflow !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: un=%b ov=%b want 1 1", underflow, overflow); end
    n_cmp++; if (rdata !== 8'h0F || count !== 5'd0) begin n_fail++; $display("FAIL drain_hold: rdata=%h count=%0d want 0f 0", rdata, count); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL drain_clr: un=%b ov=%b want 0 0", underflow, overflow); end
  endtask

  task automatic test_back_to_back;
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'h10 + 8'(i);
      tick();
    end
    n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_prefill: got %0d want 5", count); end
    rinc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wdata = 8'h15 + 8'(k);
      tick();
      n_cmp++; if (rdata !== 8'h10 + 8'(k)) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, 8'h10 + 8'(k)); end
      n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 5", k, count); end
    end
    rinc = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wdata = 8'h29 + 8'(i);
      tick();
    end
    n_cmp++; if (wfull !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL b2b_full: wfull=%b count=%0d want 1 16", wfull, count); end
    wdata = 8'hEE;
    rinc  = 1'b1;
    tick();
    winc = 1'b0;
    rinc = 1'b0;
    n_cmp++; if (count !== 5'd15 || overflow !== 1'b1 || wfull !== 1'b0) begin n_fail++; $display("FAIL full_rw: count=%0d ov=%b wfull=%b want 15 1 0", count, overflow, wfull); end
    n_cmp++; if (rdata !== 8'h24) begin n_fail++; $display("FAIL full_rw_rdata: got %h want 24", rdata); end
  endtask

  task automatic test_clr_err;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", overflow); end
    wdata = 8'h34;
    winc  = 1'b1;
    tick();
    n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL clr_refill: got %0d want 16", count); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    winc    = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins: got %b want 1", overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_again: got %b want 0", overflow); end
  endtask

  task automatic test_mid_reset;
    winc = 1'b1;
    tick();
    winc = 1'b0;
    rinc = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rinc = 1'b0;
    n_cmp++; if (count !== 5'd9 || rdata !== 8'h2B || overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset: count=%0d rdata=%h ov=%b want 9 2b 1", count, rdata, overflow); end
    rst   = 1'b1;
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 8'h77;
    tick();
    rst  = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;
    n_cmp++; if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: count=%0d rempty=%b wfull=%b want 0 1 0", count, rempty, wfull); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_err: ov=%b un=%b rdata=%h want 0 0 00", overflow, underflow, rdata); end
    winc  = 1'b1;
    wdata = 8'h5A;
    tick();
    wdata = 8'h5B;
    tick();
    winc = 1'b0;
    rinc = 1'b1;
    tick();
    n_cmp++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL post_reset_rd0: got %h want 5a", rdata); end
    tick();
    rinc = 1'b0;
    n_cmp++; if (rdata !== 8'h5B || rempty !== 1'b1) begin n_fail++; $display("FAIL post_reset_rd1: rdata=%h rempty=%b want 5b 1", rdata, rempty); end
  endtask

  task automatic test_fwft;
    f_wdata = 8'hA5;
    f_winc  = 1'b1;
    tick();
    f_winc = 1'b0;
    n_cmp++; if (f_rempty !== 1'b0 || f_rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_first: rempty=%b rdata=%h want 0 a5", f_rempty, f_rdata); end
    tick();
    n_cmp++; if (f_rdata !== 8'hA5 || f_count !== 5'd1) begin n_fail++; $display("FAIL fwft_hold: rdata=%h count=%0d want a5 1", f_rdata, f_count); end
    f_rinc = 1'b1;
    tick();
    f_rinc = 1'b0;
    n_cmp++; if (f_rempty !== 1'b1 || f_rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_pop: rempty=%b rdata=%h want 1 a5", f_rempty, f_rdata); end
    f_winc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      f_wdata = 8'(i * 8'h11);
      tick();
    end
    f_winc = 1'b0;
    n_cmp++; if (f_rdata !== 8'h11 || f_count !== 5'd3) begin n_fail++; $display("FAIL fwft_head: rdata=%h count=%0d want 11 3", f_rdata, f_count); end
    f_rinc = 1'b1;
    tick();
    n_cmp++; if (f_rdata !== 8'h22) begin n_fail++; $display("FAIL fwft_next0: got %h want 22", f_rdata); end
    tick();
    n_cmp++; if (f_rdata !== 8'h33 || f_rempty !== 1'b0) begin n_fail++; $display("FAIL fwft_next1: rdata=%h rempty=%b want 33 0", f_rdata, f_rempty); end
    tick();
    f_rinc = 1'b0;
    n_cmp++; if (f_rempty !== 1'b1 || f_rdata !== 8'h33) begin n_fail++; $display("FAIL fwft_empty: rempty=%b rdata=%h want 1 33", f_rempty, f_rdata); end
    f_wdata = 8'h44;
    f_winc  = 1'b1;
    tick();
    f_wdata = 8'h55;
    f_rinc  = 1'b1;
    tick();
    f_winc = 1'b0;
    n_cmp++; if (f_rdata !== 8'h55 || f_count !== 5'd1) begin n_fail++; $display("FAIL fwft_bypass: rdata=%h count=%0d want 55 1", f_rdata, f_count); end
    tick();
    f_rinc = 1'b0;
    n_cmp++; if (f_rempty !== 1'b1 || f_rdata !== 8'h55 || f_underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_last: rempty=%b rdata=%h un=%b want 1 55 0", f_rempty, f_rdata, f_underflow); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_clr_err();
    test_mid_reset();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
